// File: rtl/count_day.sv
// count_day: BCD day-of-month counter for the century clock.
//
// Advances on the en_day tick from the hour counter. The last day of the
// month (dmax) comes from the month-length flags TO/T/TN and the leap flag.
// pulse_d is a combinational month carry that feeds count_month.en_mo, so
// the month advances on the same edge that wraps the day back to 01.
// While en_day is low, up/down give a manual adjust.
//
// Ports:
//   clk      - system clock; all state changes on the rising edge
//   rst      - asynchronous active-high reset; forces day 01
//   en_day   - one-cycle day tick
//   up       - manual increment, only used when en_day=0
//   down     - manual decrement, only used when en_day=0
//   TO/T/TN  - current month has 31 / 30 days / is February (TN > T > TO)
//   leap     - current year is a leap year
//   day_unit - BCD units digit of the day
//   day_ten  - BCD tens digit of the day
//   pulse_d  - month carry
//
// Optional feature: define COUNT_DAY_ADJ_EDGE_EN to make up/down act on
// rising edges only (one step per press). By default the adjust is level
// sensitive and steps once per clock while a button is held.
module count_day #(
  parameter int MAX_DISPLAY_UNIT = 4,
  parameter int MAX_DISPLAY_TEN  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_day,
  input  logic                        up,
  input  logic                        down,
  input  logic                        TO,
  input  logic                        T,
  input  logic                        TN,
  input  logic                        leap,
  output logic [MAX_DISPLAY_UNIT-1:0] day_unit,
  output logic [MAX_DISPLAY_TEN-1:0]  day_ten,
  output logic                        pulse_d
);

  localparam logic [MAX_DISPLAY_UNIT-1:0] U_ZERO  = '0;
  localparam logic [MAX_DISPLAY_UNIT-1:0] U_ONE   = MAX_DISPLAY_UNIT'(1);
  localparam logic [MAX_DISPLAY_UNIT-1:0] U_EIGHT = MAX_DISPLAY_UNIT'(8);
  localparam logic [MAX_DISPLAY_UNIT-1:0] U_NINE  = MAX_DISPLAY_UNIT'(9);
  localparam logic [MAX_DISPLAY_TEN-1:0]  T_ZERO  = '0;
  localparam logic [MAX_DISPLAY_TEN-1:0]  T_ONE   = MAX_DISPLAY_TEN'(1);
  localparam logic [MAX_DISPLAY_TEN-1:0]  T_TWO   = MAX_DISPLAY_TEN'(2);
  localparam logic [MAX_DISPLAY_TEN-1:0]  T_THREE = MAX_DISPLAY_TEN'(3);

  logic [MAX_DISPLAY_UNIT-1:0] day_unit_q, day_unit_d;
  logic [MAX_DISPLAY_TEN-1:0]  day_ten_q,  day_ten_d;

  logic [MAX_DISPLAY_UNIT-1:0] dmax_unit;
  logic [MAX_DISPLAY_TEN-1:0]  dmax_ten;
  logic [7:0]                  dmax;
  logic [7:0]                  cur;
  logic                        valid;

  logic [MAX_DISPLAY_UNIT-1:0] inc_unit, dec_unit;
  logic [MAX_DISPLAY_TEN-1:0]  inc_ten,  dec_ten;

  logic                        up_step, down_step;

  // Manual adjust qualification
`ifdef COUNT_DAY_ADJ_EDGE_EN
  logic up_q, down_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      up_q   <= up;
      down_q <= down;
    end
  end

  // Registers track the buttons every cycle, so an edge seen while en_day
  // is high is consumed and never replayed later.
  assign up_step   = up   & ~up_q;
  assign down_step = down & ~down_q;
`else
  assign up_step   = up;
  assign down_step = down;
`endif

  // Last day of the current month, both as BCD digits and as a binary value
  always_comb begin
    if (TN) begin
      dmax_ten  = T_TWO;
      dmax_unit = leap ? U_NINE : U_EIGHT;
    end else if (T) begin
      dmax_ten  = T_THREE;
      dmax_unit = U_ZERO;
    end else begin
      dmax_ten  = T_THREE;
      dmax_unit = U_ONE;
    end
    dmax = 8'(dmax_ten) * 8'd10 + 8'(dmax_unit);
  end

  assign cur   = 8'(day_ten_q) * 8'd10 + 8'(day_unit_q);
  assign valid = (day_unit_q <= U_NINE) && (cur != 8'd0) && (cur <= 8'd39);

  // BCD increment / decrement of the current day
  always_comb begin
    if (day_unit_q == U_NINE) begin
      inc_unit = U_ZERO;
      inc_ten  = day_ten_q + T_ONE;
    end else begin
      inc_unit = day_unit_q + U_ONE;
      inc_ten  = day_ten_q;
    end

    if (day_unit_q == U_ZERO) begin
      dec_unit = U_NINE;
      dec_ten  = day_ten_q - T_ONE;
    end else begin
      dec_unit = day_unit_q - U_ONE;
      dec_ten  = day_ten_q;
    end
  end

  // Next-day selection, first matching rule wins
  always_comb begin
    day_unit_d = day_unit_q;
    day_ten_d  = day_ten_q;
    if (!valid) begin
      day_unit_d = U_ONE;
      day_ten_d  = T_ZERO;
    end else if (en_day) begin
      if (cur >= dmax) begin
        day_unit_d = U_ONE;
        day_ten_d  = T_ZERO;
      end else begin
        day_unit_d = inc_unit;
        day_ten_d  = inc_ten;
      end
    end else if (cur > dmax) begin
      // Month shortened underneath us: pull back to its last day
      day_unit_d = dmax_unit;
      day_ten_d  = dmax_ten;
    end else if (up_step && !down_step) begin
      if (cur == dmax) begin
        day_unit_d = U_ONE;
        day_ten_d  = T_ZERO;
      end else begin
        day_unit_d = inc_unit;
        day_ten_d  = inc_ten;
      end
    end else if (down_step && !up_step) begin
      if (cur == 8'd1) begin
        day_unit_d = dmax_unit;
        day_ten_d  = dmax_ten;
      end else begin
        day_unit_d = dec_unit;
        day_ten_d  = dec_ten;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_unit_q <= U_ONE;
      day_ten_q  <= T_ZERO;
    end else begin
      day_unit_q <= day_unit_d;
      day_ten_q  <= day_ten_d;
    end
  end

  // Zero-latency carry so count_month steps on the same edge as the wrap;
  // under reset cur is 01, which keeps this low.
  assign pulse_d  = en_day & valid & (cur >= dmax);

  assign day_unit = day_unit_q;
  assign day_ten  = day_ten_q;

endmodule

// File: tb/tb_count_day.sv
module tb_count_day;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_day = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       TO = 1'b0;
  logic       T = 1'b0;
  logic       TN = 1'b0;
  logic       leap = 1'b0;
  logic [3:0] day_unit;
  logic [1:0] day_ten;
  logic       pulse_d;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic pulse;
    int   day;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: day as a plain integer 1..31
  int   mday = 1;
  logic mup_prev = 1'b0;
  logic mdn_prev = 1'b0;

  count_day #(
    .MAX_DISPLAY_UNIT(4),
    .MAX_DISPLAY_TEN (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en_day  (en_day),
    .up      (up),
    .down    (down),
    .TO      (TO),
    .T       (T),
    .TN      (TN),
    .leap    (leap),
    .day_unit(day_unit),
    .day_ten (day_ten),
    .pulse_d (pulse_d)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1);
  end

  function automatic int dut_day();
    return int'(day_ten) * 10 + int'(day_unit);
  endfunction

  function automatic int month_len(input logic to, input logic t, input logic tn, input logic lp);
    if (tn) return lp ? 29 : 28;
    if (t)  return 30;
    return 31;
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expectation
  task automatic step(input logic r, input logic e, input logic u, input logic d,
                      input logic to, input logic t, input logic tn, input logic lp);
    exp_t x;
    int   len;
    logic ue, de;
    @(negedge clk);
    #1;
    rst = r; en_day = e; up = u; down = d;
    TO = to; T = t; TN = tn; leap = lp;
    len = month_len(to, t, tn, lp);
`ifdef COUNT_DAY_ADJ_EDGE_EN
    ue = u & ~mup_prev;
    de = d & ~mdn_prev;
`else
    ue = u;
    de = d;
`endif
    x.pulse = 1'b0;
    if (r) begin
      x.day = 1;
      mup_prev = 1'b0;
      mdn_prev = 1'b0;
    end else begin
      mup_prev = u;
      mdn_prev = d;
      if (e) begin
        x.pulse = (mday >= len);
        x.day   = x.pulse ? 1 : mday + 1;
      end else if (mday > len)   x.day = len;
      else if (ue && !de)        x.day = (mday == len) ? 1 : mday + 1;
      else if (de && !ue)        x.day = (mday == 1) ? len : mday - 1;
      else                       x.day = mday;
    end
    mday = x.day;
    exp_q.push_back(x);
    if (r) begin
      #1;
      checks++;
      if (dut_day() != 1 || pulse_d !== 1'b0) begin
        errors++;
        $display("FAIL async_reset: day %0d pulse %b, required day 1 pulse 0", dut_day(), pulse_d);
      end
    end
  endtask

  task automatic idle(input logic to, input logic t, input logic tn, input logic lp);
    step(1'b0, 1'b0, 1'b0, 1'b0, to, t, tn, lp);
  endtask

  // Reset, then tick a 31-day month up to day d
  task automatic goto_day(input int d);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < d; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: carry is checked mid-cycle, the resulting day just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pulse_d !== e.pulse) begin
          errors++;
          $display("FAIL pulse_d at %0t: actual %b required %b", $time, pulse_d, e.pulse);
        end
        @(posedge clk);
        #1;
        checks++;
        if (day_unit > 4'd9 || dut_day() != e.day) begin
          errors++;
          $display("FAIL day at %0t: actual %0d%0d required %0d", $time, day_ten, day_unit, e.day);
        end
      end
    end
  end

  initial begin
    // Reset and mid-count reset at day 17
    goto_day(17);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0, 1'b0);

    // Full 31-day month, wrap on the 31st tick
    goto_day(1);
    repeat (31) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // February, non-leap and leap
    goto_day(28);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    goto_day(28);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Clamp 31 -> 30, and the same switch with a tick
    goto_day(31);
    idle(1'b0, 1'b1, 1'b0, 1'b0);
    goto_day(31);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Manual adjust in a 30-day month
    goto_day(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    goto_day(9);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Button held five cycles at day 05
    goto_day(5);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checks++;
`ifdef COUNT_DAY_ADJ_EDGE_EN
    if (dut_day() != 6) begin
      errors++;
      $display("FAIL held_up_edge: actual %0d required 6", dut_day());
    end
`else
    if (dut_day() != 10) begin
      errors++;
      $display("FAIL held_up_level: actual %0d required 10", dut_day());
    end
`endif
    idle(1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic, flags change freely to exercise clamping
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
